// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Double-dabble adjust thresholds and the FSM state encoding live here.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADJUST,
        SHIFT,
        DONE
    } state_t;

    localparam int          BCD_DIGIT_W    = 4;
    localparam logic [3:0]  BCD_ADJ_THRESH = 4'd4;
    localparam logic [3:0]  BCD_ADJ_ADD    = 4'd3;
    localparam logic [3:0]  BCD_MAX_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Add-3-if-greater-than-4 cell for one BCD digit.
// Inputs above 9 never occur, so the 4-bit sum cannot wrap.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit > BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done.
// Optional LEADING_ZERO_BLANK_EN registers per-digit leading-zero blanking.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          start,
    input  logic [DATA_W-1:0]             data,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]             digit_en
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + DATA_W;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [BCD_W-1:0] BCD_SAT  = {DIGITS{BCD_MAX_DIGIT}};

    state_t              state;
    state_t              state_nxt;
    logic [WORK_W-1:0]   work;
    logic [CNT_W-1:0]    cnt;
    logic                carry;
    logic [BCD_W-1:0]    adj_bcd;
    logic [BCD_W-1:0]    res;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (work[DATA_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adj   (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? ADJUST : IDLE;
            ADJUST:  state_nxt = SHIFT;
            SHIFT:   state_nxt = (cnt == CNT_LAST) ? DONE : ADJUST;
            DONE:    state_nxt = IDLE;
        endcase
    end

    assign busy = (state == ADJUST) || (state == SHIFT);

    // Carry keeps any digit shifted past the top: the value needs more digits
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            work  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work  <= {{BCD_W{1'b0}}, data};
                        cnt   <= '0;
                        carry <= 1'b0;
                    end
                end
                ADJUST: work[WORK_W-1 -: BCD_W] <= adj_bcd;
                SHIFT: begin
                    carry <= carry | work[WORK_W-1];
                    work  <= work << 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                DONE: ;
            endcase
        end
    end

    assign res = carry ? BCD_SAT : work[WORK_W-1 -: BCD_W];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                overflow <= carry;
                bcd      <= res;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] en_nxt;
    logic              seen;

    always_comb begin
        seen   = 1'b0;
        en_nxt = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen      = seen | (res[i*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'd0);
            en_nxt[i] = seen | (i == 0);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)          digit_en <= DIGITS'(1);
        else if (state == DONE)  digit_en <= en_nxt;
    end
`else
    assign digit_en = '1;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default 20b/6-digit and a 4-digit build.
// Stimulus pushes expectations; negedge monitors pop and compare on done.
module tb_bin2bcd_seq;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        logic [5:0]  den;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;

    logic        start_a = 1'b0;
    logic [19:0] data_a = '0;
    logic        busy_a, done_a, ovf_a;
    logic [23:0] bcd_a;
    logic [5:0]  den_a;

    logic        start_b = 1'b0;
    logic [19:0] data_b = '0;
    logic        busy_b, done_b, ovf_b;
    logic [15:0] bcd_b;
    logic [3:0]  den_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   passes = 0;
    int   dones_a = 0;

    always #5 sys_clk = ~sys_clk;

    bin2bcd_seq u_dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start_a),
        .data      (data_a),
        .busy      (busy_a),
        .done      (done_a),
        .overflow  (ovf_a),
        .bcd       (bcd_a),
        .digit_en  (den_a)
    );

    bin2bcd_seq #(.DATA_W(20), .DIGITS(4)) u_dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start_b),
        .data      (data_b),
        .busy      (busy_b),
        .done      (done_b),
        .overflow  (ovf_b),
        .bcd       (bcd_b),
        .digit_en  (den_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] den6(input logic [5:0] v);
        return LZB ? v : 6'h3f;
    endfunction

    function automatic logic [5:0] den4(input logic [3:0] v);
        return LZB ? {2'b00, v} : 6'h0f;
    endfunction

    always @(negedge sys_clk) begin : mon_a
        exp_t e;
        if (done_a) begin
            dones_a++;
            if (q_a.size() == 0) begin
                checks++;
                $display("FAIL a_unexpected_done: bcd %0h", bcd_a);
            end else begin
                e = q_a.pop_front();
                chk("a_bcd", bcd_a, e.bcd);
                chk("a_ovf", ovf_a, e.ovf);
                chk("a_digit_en", den_a, e.den);
            end
        end
    end

    always @(negedge sys_clk) begin : mon_b
        exp_t e;
        if (done_b) begin
            if (q_b.size() == 0) begin
                checks++;
                $display("FAIL b_unexpected_done: bcd %0h", bcd_b);
            end else begin
                e = q_b.pop_front();
                chk("b_bcd", bcd_b, e.bcd);
                chk("b_ovf", ovf_b, e.ovf);
                chk("b_digit_en", den_b, e.den);
            end
        end
    end

    task automatic wait_a(output int n);
        n = 0;
        while (!done_a && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (!done_a) begin
            checks++;
            $display("FAIL a_timeout: no done after %0d cycles", n);
        end
    endtask

    task automatic run_a(input logic [19:0] d, input logic [23:0] eb,
                         input logic eo, input logic [5:0] ed,
                         output int lat, output int bsy);
        q_a.push_back('{eb, eo, den6(ed)});
        @(negedge sys_clk);
        start_a = 1'b1;
        data_a  = d;
        @(negedge sys_clk);
        start_a = 1'b0;
        lat = 0;
        bsy = 0;
        while (!done_a && lat < 200) begin
            if (busy_a) bsy++;
            @(negedge sys_clk);
            lat++;
        end
        if (!done_a) begin
            checks++;
            $display("FAIL a_timeout: no done after %0d cycles", lat);
        end
    endtask

    task automatic run_b(input logic [19:0] d, input logic [15:0] eb,
                         input logic eo, input logic [3:0] ed);
        int n;
        q_b.push_back('{{8'h00, eb}, eo, den4(ed)});
        @(negedge sys_clk);
        start_b = 1'b1;
        data_b  = d;
        @(negedge sys_clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (!done_b) begin
            checks++;
            $display("FAIL b_timeout: no done after %0d cycles", n);
        end
    endtask

    initial begin
        int lat, bsy, gap, snap;

        repeat (3) @(negedge sys_clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_bcd", bcd_a, 0);
        chk("rst_digit_en", den_a, LZB ? 6'h01 : 6'h3f);
        chk("rst_b_bcd", bcd_b, 0);
        chk("rst_b_digit_en", den_b, LZB ? 4'h1 : 4'hf);
        sys_rst_n = 1'b1;

        run_a(20'd123456, 24'h123456, 1'b0, 6'h3f, lat, bsy);
        chk("latency_edges", lat, 41);
        chk("busy_cycles", bsy, 40);

        q_a.push_back('{24'h000000, 1'b0, den6(6'h01)});
        q_a.push_back('{24'h999999, 1'b0, den6(6'h3f)});
        @(negedge sys_clk);
        start_a = 1'b1;
        data_a  = 20'd0;
        @(negedge sys_clk);
        data_a  = 20'd999999;
        wait_a(gap);
        @(negedge sys_clk);
        start_a = 1'b0;
        gap = 1;
        while (!done_a && gap < 200) begin
            @(negedge sys_clk);
            gap++;
        end
        chk("b2b_done_spacing", gap, 42);

        q_a.push_back('{24'h000777, 1'b0, den6(6'h07)});
        @(negedge sys_clk);
        start_a = 1'b1;
        data_a  = 20'd777;
        @(negedge sys_clk);
        start_a = 1'b0;
        repeat (10) @(negedge sys_clk);
        start_a = 1'b1;
        data_a  = 20'd5;
        repeat (5) @(negedge sys_clk);
        start_a = 1'b0;
        wait_a(gap);
        @(negedge sys_clk);
        snap = dones_a;
        repeat (60) @(negedge sys_clk);
        chk("no_extra_done", dones_a - snap, 0);
        chk("bcd_hold", bcd_a, 24'h000777);

        @(negedge sys_clk);
        start_a = 1'b1;
        data_a  = 20'd5;
        @(negedge sys_clk);
        start_a = 1'b0;
        repeat (9) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_bcd", bcd_a, 0);
        chk("midrst_ovf", ovf_a, 0);
        chk("midrst_digit_en", den_a, LZB ? 6'h01 : 6'h3f);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        run_a(20'd42, 24'h000042, 1'b0, 6'h03, lat, bsy);
        run_a(20'd100000, 24'h100000, 1'b0, 6'h3f, lat, bsy);

        run_b(20'd9999, 16'h9999, 1'b0, 4'hf);
        run_b(20'd10000, 16'h9999, 1'b1, 4'hf);
        run_b(20'hFFFFF, 16'h9999, 1'b1, 4'hf);

        repeat (5) @(negedge sys_clk);
        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
